string_feeder: RTL

STRING_FEEDER -- requirements
Module: string_feeder

---
 rtl/string_feeder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/string_feeder.sv
// string_feeder: paces pixels from an upstream FIFO into a serial LED string driver.
// Define STRING_FEEDER_GRB_EN to reorder pixels to {G,R,B} wire order at load time.
module string_feeder #(
  parameter int unsigned PIXELS_PER_STRING = 150,
  parameter int unsigned CNT_W             = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [23:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [23:0] pixel_data,
  output logic        pixel_data_valid,
  output logic        h_blank,
  input  logic        string_ready,
  output logic        busy,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int unsigned PIX_W = 24;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    HOLD,
    WAIT_RDY,
    BLANK,
    BLANK_HOLD,
    BLANK_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [PIX_W-1:0]   pix_order;
  logic               rd_en_q, rd_en_d;
  logic               valid_q, valid_d;
  logic               hblank_q, hblank_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               underrun_set;

`ifdef STRING_FEEDER_GRB_EN
  assign pix_order = {fifo_data[15:8], fifo_data[23:16], fifo_data[7:0]};
`else
  assign pix_order = fifo_data;
`endif

  // Pops are decided one cycle ahead so fifo_rd_en is a flop output and lands in FETCH.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pix_d        = pix_q;
    rd_en_d      = 1'b0;
    valid_d      = 1'b0;
    hblank_d     = 1'b0;
    busy_d       = busy_q;
    underrun_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start && string_ready) begin
          cnt_d   = CNT_W'(PIXELS_PER_STRING);
          busy_d  = 1'b1;
          rd_en_d = ~fifo_empty;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rd_en_q) begin
          state_d = LOAD;
        end else if (fifo_empty) begin
          underrun_set = 1'b1;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      LOAD: begin
        pix_d   = pix_order;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = HOLD;
      end
      HOLD: begin
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (string_ready) begin
          if (cnt_q != '0) begin
            rd_en_d = ~fifo_empty;
            state_d = FETCH;
          end else begin
            hblank_d = 1'b1;
            state_d  = BLANK;
          end
        end
      end
      BLANK: begin
        state_d = BLANK_HOLD;
      end
      BLANK_HOLD: begin
        state_d = BLANK_WAIT;
      end
      BLANK_WAIT: begin
        if (string_ready) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stall in the same cycle as a clear keeps the flag set.
    underrun_d = underrun_set | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pix_q      <= '0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      hblank_q   <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      hblank_q   <= hblank_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo_rd_en       = rd_en_q;
  assign pixel_data       = pix_q;
  assign pixel_data_valid = valid_q;
  assign h_blank          = hblank_q;
  assign busy             = busy_q;
  assign underrun         = underrun_q;

endmodule
